// File: rtl/gf_mul_by2.sv
// Registered GF(2^8) xtime unit: each byte lane is multiplied by {02} modulo 0x11B.
// One or two register stages; the valid sideband is delayed alongside the data.
module gf_mul_by2 #(
  parameter int BYTES = 1,
  parameter int PIPE  = 1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [8*BYTES-1:0] MulBy2In,
  input  logic               InValid,
  output logic [8*BYTES-1:0] MulBy2Out,
  output logic               OutValid
);

  localparam int W = 8 * BYTES;

  // Shift left; fold the bit shifted out of x^7 back in as x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1B & {8{b[7]}});
  endfunction

  logic [W-1:0] prodP0;
  logic         vldP0;

  always_comb begin
    prodP0 = '0;
    for (int k = 0; k < BYTES; k++) begin
      prodP0[8*k +: 8] = xtime(MulBy2In[8*k +: 8]);
    end
  end

  assign vldP0 = InValid;

  // Stage 1: captured every edge, valid or not.
  logic [W-1:0] prodP1;
  logic         vldP1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prodP1 <= '0;
      vldP1  <= 1'b0;
    end else begin
      prodP1 <= prodP0;
      vldP1  <= vldP0;
    end
  end

  generate
    if (PIPE == 2) begin : gTwoStage
      // Stage 2: straight copy of stage 1.
      logic [W-1:0] prodP2;
      logic         vldP2;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          prodP2 <= '0;
          vldP2  <= 1'b0;
        end else begin
          prodP2 <= prodP1;
          vldP2  <= vldP1;
        end
      end

      assign MulBy2Out = prodP2;
      assign OutValid  = vldP2;
    end else if (PIPE == 1) begin : gOneStage
      assign MulBy2Out = prodP1;
      assign OutValid  = vldP1;
    end else begin : gBadPipe
      $error("gf_mul_by2: PIPE must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_gf_mul_by2.sv
// Bench for gf_mul_by2: a 1-byte single-stage instance and a 4-byte two-stage instance
// checked through per-instance expectation queues tagged with the expected output cycle.
module tb_gf_mul_by2;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [7:0]  inA = '0;
  logic        invA = 1'b0;
  logic [7:0]  outA;
  logic        ovA;
  logic [31:0] inB = '0;
  logic        invB = 1'b0;
  logic [31:0] outB;
  logic        ovB;

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;
  exp_t qA[$];
  exp_t qB[$];

  gf_mul_by2 #(.BYTES(1), .PIPE(1)) dutA (
    .Clk(Clk), .Rst_n(Rst_n), .MulBy2In(inA), .InValid(invA),
    .MulBy2Out(outA), .OutValid(ovA)
  );

  gf_mul_by2 #(.BYTES(4), .PIPE(2)) dutB (
    .Clk(Clk), .Rst_n(Rst_n), .MulBy2In(inB), .InValid(invB),
    .MulBy2Out(outB), .OutValid(ovB)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: multiply by x as polynomial, then reduce by 0x11B.
  function automatic logic [7:0] refXtime(input logic [7:0] b);
    logic [8:0] t;
    t = {b, 1'b0};
    if (t[8]) t = t ^ 9'h11B;
    return t[7:0];
  endfunction

  // Monitors: pop one expectation for every valid output.
  always @(negedge Clk) begin
    if (ovA === 1'b1) begin
      if (qA.size() == 0) begin
        nCmp++; nErr++;
        $display("FAIL monA_unexpected: got %h with OutValid, expected no output", outA);
      end else begin
        exp_t e;
        e = qA.pop_front();
        chk("monA_data", {24'h0, outA}, e.data);
        chk("monA_latency", cyc, e.cyc);
      end
    end
    if (ovB === 1'b1) begin
      if (qB.size() == 0) begin
        nCmp++; nErr++;
        $display("FAIL monB_unexpected: got %h with OutValid, expected no output", outB);
      end else begin
        exp_t e;
        e = qB.pop_front();
        chk("monB_data", outB, e.data);
        chk("monB_latency", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setA(input logic [7:0] d, input logic v, input logic [7:0] e);
    exp_t x;
    inA = d;
    invA = v;
    if (v) begin
      x.data = {24'h0, e};
      x.cyc = cyc + 1;
      qA.push_back(x);
    end
  endtask

  task automatic setB(input logic [31:0] d, input logic v, input logic [31:0] e);
    exp_t x;
    inB = d;
    invB = v;
    if (v) begin
      x.data = e;
      x.cyc = cyc + 2;
      qB.push_back(x);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] holdIn [4];
    logic [7:0] holdEx [4];
    logic [7:0] bndIn [4];
    logic [7:0] bndEx [4];
    holdIn = '{8'd123, 8'd255, 8'd234, 8'd23};
    holdEx = '{8'd246, 8'd229, 8'd207, 8'd46};
    bndIn  = '{8'h80, 8'h7F, 8'h00, 8'h01};
    bndEx  = '{8'h1B, 8'hFE, 8'h00, 8'h02};

    // Reset state with no clock edge needed.
    #1;
    chk("rstA_out", {24'h0, outA}, 32'h0);
    chk("rstA_vld", {31'h0, ovA}, 32'h0);
    chk("rstB_out", outB, 32'h0);
    chk("rstB_vld", {31'h0, ovB}, 32'h0);
    #12;
    Rst_n = 1'b1;

    // Hold each value for five clock periods.
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 5; r++) begin
        step();
        setA(holdIn[i], 1'b1, holdEx[i]);
      end

    for (int i = 0; i < 4; i++) begin
      step();
      setA(bndIn[i], 1'b1, bndEx[i]);
    end

    for (int i = 0; i < 256; i++) begin
      step();
      setA(i[7:0], 1'b1, refXtime(i[7:0]));
    end

    // Input change between edges must not reach the output.
    step();
    setA(8'h80, 1'b0, 8'h00);
    step();
    #2;
    inA = 8'h01;
    #1;
    chk("noGlitch", {24'h0, outA}, 32'h1B);
    step();
    chk("afterEdge", {24'h0, outA}, 32'h02);

    // Lane independence and valid toggling on the 4-byte two-stage unit.
    step(); setB(32'h80FF0117, 1'b1, 32'h1BE5022E);
    step(); setB(32'h01020304, 1'b1, 32'h02040608);
    step(); setB(32'h11111111, 1'b0, 32'h0);
    step(); setB(32'h80808080, 1'b1, 32'h1B1B1B1B);
    step(); setB(32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();

    // Mid-stream reset: settle on 0xFF, put an unchecked valid into B, then reset it away.
    setA(8'hFF, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step();
    chk("preRstA", {24'h0, outA}, 32'hE5);
    setB(32'hFFFFFFFF, 1'b1, 32'h0);
    qB.delete();
    step();
    setB(32'hFFFFFFFF, 1'b0, 32'h0);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("midRstA_out", {24'h0, outA}, 32'h0);
    chk("midRstA_vld", {31'h0, ovA}, 32'h0);
    chk("midRstB_out", outB, 32'h0);
    chk("midRstB_vld", {31'h0, ovB}, 32'h0);
    step();
    chk("holdRstA_out", {24'h0, outA}, 32'h0);
    @(negedge Clk);
    #2;
    Rst_n = 1'b1;
    step();
    setA(8'hFF, 1'b1, 8'hE5);
    setB(32'hFFFFFFFF, 1'b1, 32'hE5E5E5E5);
    step();
    setA(8'hFF, 1'b0, 8'h00);
    setB(32'hFFFFFFFF, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();

    chk("drainA", qA.size(), 32'd0);
    chk("drainB", qB.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/gf_mul_by2.md
# gf_mul_by2

Registered GF(2^8) multiply-by-2 ("xtime") unit for the AES-128 datapath. Each input byte is multiplied by {02} modulo the AES polynomial x^8+x^4+x^3+x+1 (0x11B). Results are registered on the rising clock edge. It is the primitive beneath MixColumns, where ×3 = ×2 XOR ×1, and beneath key-schedule Rcon generation.

## Interface
Parameters:
- BYTES, default 1: number of independent byte lanes; datapath width is 8*BYTES.
- PIPE, default 1: number of register stages between input and output. Legal values are 1 and 2.

Ports:
- Clk, input, 1: single clock; rising edge active.
- Rst_n, input, 1: asynchronous active-low reset.
- MulBy2In, input, 8*BYTES: operand bytes; lane k is bits [8k+7:8k].
- InValid, input, 1: qualifies MulBy2In on the current edge.
- MulBy2Out, output, 8*BYTES: product bytes, lane-aligned with the input.
- OutValid, output, 1: MulBy2Out holds a result produced from a valid input.

## Operation
- Per lane, with input byte b:
  - If b[7]=0, out = {b[6:0],1'b0}.
  - If b[7]=1, out = {b[6:0],1'b0} XOR 8'h1B.
- Lanes are fully independent. There is no carry or interaction between bytes.
- The arithmetic is pure combinational XOR/shift; no adders and no lookup tables.
- Inputs are captured on every rising Clk edge regardless of InValid.
  - MulBy2Out follows the input stream continuously.
  - InValid only travels alongside the data as a sideband bit that becomes OutValid.
- There is no backpressure or ready signal; the unit accepts a new operand every cycle.
- When PIPE=2, the combinational xtime result goes into stage 1, stage 1 feeds stage 2, and stage 2 drives the outputs. The valid bit is delayed identically.

## Timing
- Reset (Rst_n low, asynchronous):
  - MulBy2Out = 0, OutValid = 0, and all internal pipeline stages = 0, immediately, with no clock required.
- Reset release: the first edge with Rst_n high captures the input normally.
- Latency: exactly PIPE rising edges from input to output. Throughput is one result per cycle.
- An input held constant keeps the output constant, equal to xtime(input), from PIPE edges after the input is applied.
- Reset asserted mid-stream flushes all in-flight results. OutValid drops the same instant and stays 0 until valid data has propagated again after release.
- An input change between edges has no effect on the output until the next edge; the output must not glitch combinationally.
- Boundary values:
  - 0x00 → 0x00.
  - 0x80 → 0x1B.
  - 0xFF → 0xE5.
  - 0x7F → 0xFE, the largest value with no reduction.

## Test plan
- BYTES=1, PIPE=1, 50-time-unit hold per value (clock period 10): apply 123, 255, 234, 23 → after one edge, MulBy2Out = 246, 229, 207, 46 respectively.
- Reduction boundary: apply 0x80 → 0x1B; 0x7F → 0xFE; 0x00 → 0x00; 0x01 → 0x02.
- Exhaustive: sweep all 256 inputs with InValid=1, one per cycle. Compare against a reference model with latency PIPE. OutValid is high exactly on those result cycles.
- Reset: drive 0xFF for several cycles, then pull Rst_n low between edges → MulBy2Out = 0x00 and OutValid = 0 immediately. Release, then after PIPE edges the output = 0xE5.
- BYTES=4, PIPE=2: input 0x80FF0117 → 0x1BE5022E after two edges, with lanes independent. Toggling InValid 1,0,1 → OutValid 1,0,1 delayed by 2 cycles.
